// File: rtl/dot_product_stream.sv
// Pipelined signed fixed-point dot product: N-lane multiply, registered adder tree,
// packet accumulator framed by in_last, saturated WIDTH-bit result per packet.
module dot_product_stream #(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 16,
  parameter int N          = 4,
  parameter int GUARD_BITS = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [N*WIDTH-1:0]   x_in,
  input  logic [N*WIDTH-1:0]   y_in,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned LOG2N  = $clog2(N);
  localparam int          PW     = 2 * WIDTH;
  localparam int          TREE_W = PW + LOG2N;
  localparam int          ACC_W  = TREE_W + GUARD_BITS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                     en;
  logic signed [PW-1:0]     prod [N];
  logic signed [TREE_W-1:0] tree_q [LOG2N+1][N];
  logic [LOG2N:0]           vld_q;
  logic [LOG2N:0]           lst_q;

  logic signed [ACC_W-1:0]  acc_q;
  logic                     first_q;
  logic signed [ACC_W-1:0]  tree_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [WIDTH-1:0]         sat_val;
  logic                     clip;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod[i] = $signed({{WIDTH{x_in[i*WIDTH+WIDTH-1]}}, x_in[i*WIDTH +: WIDTH]}) *
                $signed({{WIDTH{y_in[i*WIDTH+WIDTH-1]}}, y_in[i*WIDTH +: WIDTH]});
    end
  end

  // Tree terms are carried at the final tree width; sign extension makes this
  // equivalent to growing one bit per level with no truncation.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned l = 0; l <= LOG2N; l++) begin
        for (int unsigned i = 0; i < N; i++) begin
          tree_q[l][i] <= '0;
        end
      end
      vld_q <= '0;
      lst_q <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        tree_q[0][i] <= TREE_W'(prod[i]);
      end
      for (int unsigned l = 1; l <= LOG2N; l++) begin
        for (int unsigned i = 0; i < (N >> l); i++) begin
          tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
        end
      end
      vld_q <= {vld_q[LOG2N-1:0], in_valid};
      lst_q <= {lst_q[LOG2N-1:0], in_last};
    end
  end

  always_comb begin
    tree_ext = ACC_W'(tree_q[LOG2N][0]);
    sum      = (first_q ? '0 : acc_q) + tree_ext;
    shifted  = sum >>> FRAC_BITS;
    sat_val  = shifted[WIDTH-1:0];
    clip     = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[WIDTH-1:0];
      clip    = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[WIDTH-1:0];
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      out       <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (vld_q[LOG2N]) begin
        if (lst_q[LOG2N]) begin
          out       <= sat_val;
          out_sat   <= clip;
          out_valid <= 1'b1;
          acc_q     <= '0;
          first_q   <= 1'b1;
        end else begin
          acc_q     <= sum;
          first_q   <= 1'b0;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed self-checking bench for dot_product_stream at Q16.16, N=4.
module tb_dot_product_stream;

  localparam int W = 32;
  localparam int L = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [L*W-1:0]   x_in;
  logic [L*W-1:0]   y_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [W-1:0]     out;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  dot_product_stream #(
    .WIDTH(W),
    .FRAC_BITS(16),
    .N(L),
    .GUARD_BITS(4)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .x_in(x_in),
    .y_in(y_in),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out(out),
    .out_sat(out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input logic [L*W-1:0] x, input logic [L*W-1:0] y, input logic last);
    x_in     = x;
    y_in     = y;
    in_valid = 1'b1;
    in_last  = last;
  endtask

  task automatic wait_result(input string tag);
    int budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    if (!out_valid) check(tag, {63'd0, out_valid}, 64'd1);
  endtask

  logic [L*W-1:0] xa, ya, xb, yb;

  initial begin
    int pulses;
    logic [W-1:0] captured;
    int sent, recv;
    logic stalled_prev, accept;
    logic [W-1:0] prev_out;

    xa = pack4(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    ya = pack4(32'h0001_8000, 32'h0004_C000, 32'h0008_D000, 32'h0010_0000);
    xb = pack4(32'hFFFA_8000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    yb = pack4(32'h0001_8000, 32'h0004_C000, 32'h0008_D000, 32'hFFEF_8000);

    rst_n_in  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    check("reset_out", out, 0);
    check("reset_sat", out_sat, 0);
    check("reset_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n_in = 1'b1;
    tick();

    // Latency and back-to-back single-beat packets
    drive(xa, ya, 1'b1);
    check("lat_in_ready", in_ready, 1);
    tick();
    drive(xb, yb, 1'b1);
    check("lat_edge1", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("lat_edge2", out_valid, 0);
    tick();
    check("lat_edge3", out_valid, 0);
    tick();
    check("lat_edge4_valid", out_valid, 1);
    check("lat_edge4_out", out, 32'h0065_7000);
    check("lat_edge4_sat", out_sat, 0);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_out", out, 32'hFFD9_B000);
    check("b2b_sat", out_sat, 0);
    tick();
    check("b2b_done", out_valid, 0);

    // Two-beat packet gives one result
    drive(xa, ya, 1'b0);
    tick();
    drive(xa, ya, 1'b1);
    tick();
    in_valid = 1'b0;
    pulses   = 0;
    captured = '0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        pulses++;
        captured = out;
      end
      tick();
    end
    check("multi_pulses", pulses, 1);
    check("multi_out", captured, 32'h00CA_E000);

    // Positive saturation
    drive({L{32'h7FFF_0000}}, {L{32'h7FFF_0000}}, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_result("sat_pos_timeout");
    check("sat_pos_out", out, 32'h7FFF_FFFF);
    check("sat_pos_sat", out_sat, 1);
    tick();

    // Negative saturation
    drive({L{32'h7FFF_0000}}, {L{32'h8001_0000}}, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_result("sat_neg_timeout");
    check("sat_neg_out", out, 32'h8000_0000);
    check("sat_neg_sat", out_sat, 1);
    tick();

    // Reset mid-packet: a non-last beat sits in the accumulator
    drive(xa, ya, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("rst_async_out", out, 0);
    check("rst_async_sat", out_sat, 0);
    check("rst_async_valid", out_valid, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    drive(xa, ya, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_result("rst_residue_timeout");
    check("rst_residue_out", out, 32'h0065_7000);
    tick();

    // Rounding toward negative infinity
    drive(pack4(32'h0000_0001, 0, 0, 0), pack4(32'hFFFF_8000, 0, 0, 0), 1'b1);
    tick();
    in_valid = 1'b0;
    wait_result("round_timeout");
    check("round_out", out, 32'hFFFF_FFFF);
    check("round_sat", out_sat, 0);
    tick();

    // Backpressure: out_ready toggles every 3 cycles; results are k.0 for k=1..8
    sent = 0;
    recv = 0;
    stalled_prev = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
      out_ready = ((cyc / 3) % 2) == 0;
      in_valid  = sent < 8;
      in_last   = 1'b1;
      x_in      = pack4(32'((sent + 1) << 16), 0, 0, 0);
      y_in      = pack4(32'h0001_0000, 0, 0, 0);
      #1;
      check("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (stalled_prev) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_out", out, prev_out);
      end
      if (out_valid && out_ready) begin
        check("bp_order", out, 32'((recv + 1) << 16));
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_out     = out;
      accept       = in_valid && in_ready;
      @(posedge clk_in);
      if (accept) sent++;
      @(negedge clk_in);
    end
    check("bp_all_received", recv, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("bp_no_extra", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
